// File: rtl/flash_op_sequencer_if.sv
// flash_op_sequencer_if
//   Groups the controller-side request/data signals and the translator-side
//   bus-mode outputs of the flash operation sequencer into one bundle.
//   master : the SSD controller / translator side (drives requests, R/B, data)
//   slave  : the sequencer itself
// Signals
//   start, op[1:0], die_sel, col_addr[15:0], row_addr[23:0] : operation request
//   rb1_ctrl, rb2_ctrl                                        : die ready/busy (1 = ready)
//   wdata_valid, wdata[7:0], wdata_ready                      : program data stream
//   rdata_ready, rdata_strobe                                 : read data stream
//   cmd_mode[2:0], ce, dq_out[7:0]                            : translator bus controls
//   busy, done, timeout                                       : operation status
interface flash_op_sequencer_if;
  logic        start;
  logic [1:0]  op;
  logic        die_sel;
  logic [15:0] col_addr;
  logic [23:0] row_addr;
  logic        rb1_ctrl;
  logic        rb2_ctrl;
  logic        wdata_valid;
  logic [7:0]  wdata;
  logic        rdata_ready;
  logic [2:0]  cmd_mode;
  logic        ce;
  logic [7:0]  dq_out;
  logic        wdata_ready;
  logic        rdata_strobe;
  logic        busy;
  logic        done;
  logic        timeout;

  modport master (
    output start, op, die_sel, col_addr, row_addr, rb1_ctrl, rb2_ctrl,
           wdata_valid, wdata, rdata_ready,
    input  cmd_mode, ce, dq_out, wdata_ready, rdata_strobe, busy, done, timeout
  );

  modport slave (
    input  start, op, die_sel, col_addr, row_addr, rb1_ctrl, rb2_ctrl,
           wdata_valid, wdata, rdata_ready,
    output cmd_mode, ce, dq_out, wdata_ready, rdata_strobe, busy, done, timeout
  );
endinterface

// File: rtl/flash_op_sequencer.sv
// flash_op_sequencer
//   Runs one NAND operation (RESET, READ PAGE, PROGRAM PAGE, ERASE BLOCK) by
//   emitting one bus-mode code per cycle, plus die select and command/address/
//   data bytes, towards the flash command translator. Waits on the selected
//   die's ready/busy line and streams page data with simple handshakes.
//   Every output is a register: the values seen in a cycle were decided at the
//   clock edge that began it, so data handshakes report the byte taken at the
//   previous edge.
// Ports
//   clock_100 : system clock, rising edge
//   rst       : synchronous active-high reset
//   bus       : flash_op_sequencer_if.slave (request, R/B, data streams, outputs)
module flash_op_sequencer #(
  parameter int PAGE_BYTES     = 2048,
  parameter int TWB_CYCLES     = 10,
  parameter int TIMEOUT_CYCLES = 400000,
  parameter int CNT_W          = 12
) (
  input logic                  clock_100,
  input logic                  rst,
  flash_op_sequencer_if.slave  bus
);

  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WAIT_W-1:0] TWB_LAST  = WAIT_W'(TWB_CYCLES - 1);
  localparam logic [WAIT_W-1:0] TO_LAST   = WAIT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]  BYTE_LAST = CNT_W'(PAGE_BYTES - 1);

  localparam logic [2:0] MODE_STANDBY = 3'd0;
  localparam logic [2:0] MODE_IDLE    = 3'd1;
  localparam logic [2:0] MODE_CMD     = 3'd3;
  localparam logic [2:0] MODE_ADDR    = 3'd4;
  localparam logic [2:0] MODE_DIN     = 3'd5;
  localparam logic [2:0] MODE_DOUT    = 3'd6;

  typedef enum logic [1:0] {OP_RESET, OP_READ, OP_PROGRAM, OP_ERASE} op_t;

  typedef enum logic [3:0] {
    ST_IDLE, ST_CMD1, ST_ADDR, ST_DIN, ST_CMD2,
    ST_WAIT_WB, ST_WAIT_RB, ST_DOUT, ST_DONE
  } state_t;

  state_t            r_state;
  op_t               r_op;
  logic              r_dieSel;
  logic [15:0]       r_colAddr;
  logic [23:0]       r_rowAddr;
  logic              r_gap;
  logic [2:0]        r_addrIdx;
  logic [CNT_W-1:0]  r_byteCnt;
  logic              r_pageDone;
  logic [WAIT_W-1:0] r_waitCnt;

  logic w_rbReady;
  logic w_lastByte;
  logic w_lastAddr;

  function automatic logic [7:0] cmd1Byte(input op_t op);
    case (op)
      OP_RESET:   cmd1Byte = 8'hFF;
      OP_READ:    cmd1Byte = 8'h00;
      OP_PROGRAM: cmd1Byte = 8'h80;
      default:    cmd1Byte = 8'h60;
    endcase
  endfunction

  function automatic logic [7:0] cmd2Byte(input op_t op);
    case (op)
      OP_READ:    cmd2Byte = 8'h30;
      OP_PROGRAM: cmd2Byte = 8'h10;
      default:    cmd2Byte = 8'hD0;
    endcase
  endfunction

  // Address byte order: col low, col high, row low, row mid, row high.
  // ERASE starts at index 2 so it only sends the row bytes.
  function automatic logic [7:0] addrByte(input logic [2:0] idx,
                                          input logic [15:0] col,
                                          input logic [23:0] row);
    case (idx)
      3'd0:    addrByte = col[7:0];
      3'd1:    addrByte = col[15:8];
      3'd2:    addrByte = row[7:0];
      3'd3:    addrByte = row[15:8];
      default: addrByte = row[23:16];
    endcase
  endfunction

  // Only the selected die's ready/busy line is ever looked at.
  assign w_rbReady  = r_dieSel ? bus.rb2_ctrl : bus.rb1_ctrl;
  assign w_lastByte = (r_byteCnt == BYTE_LAST);
  assign w_lastAddr = (r_addrIdx == 3'd4);

  // Single FSM register block. Each branch decides the next state together
  // with the bus outputs for the coming cycle; command/address bytes use
  // r_gap to insert the bus_idle cycle after each byte. The byte counter
  // stops at PAGE_BYTES-1 and r_pageDone marks the final accepted byte, so
  // it never wraps.
  always_ff @(posedge clock_100) begin
    if (rst) begin
      r_state          <= ST_IDLE;
      r_op             <= OP_RESET;
      r_dieSel         <= 1'b0;
      r_colAddr        <= '0;
      r_rowAddr        <= '0;
      r_gap            <= 1'b0;
      r_addrIdx        <= '0;
      r_byteCnt        <= '0;
      r_pageDone       <= 1'b0;
      r_waitCnt        <= '0;
      bus.cmd_mode     <= MODE_STANDBY;
      bus.ce           <= 1'b1;
      bus.dq_out       <= '0;
      bus.wdata_ready  <= 1'b0;
      bus.rdata_strobe <= 1'b0;
      bus.busy         <= 1'b0;
      bus.done         <= 1'b0;
      bus.timeout      <= 1'b0;
    end else begin
      bus.cmd_mode     <= MODE_IDLE;
      bus.dq_out       <= '0;
      bus.wdata_ready  <= 1'b0;
      bus.rdata_strobe <= 1'b0;
      bus.done         <= 1'b0;
      bus.timeout      <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          bus.cmd_mode <= MODE_STANDBY;
          if (bus.start) begin
            r_op         <= op_t'(bus.op);
            r_dieSel     <= bus.die_sel;
            r_colAddr    <= bus.col_addr;
            r_rowAddr    <= bus.row_addr;
            r_gap        <= 1'b0;
            r_addrIdx    <= '0;
            r_byteCnt    <= '0;
            r_pageDone   <= 1'b0;
            r_waitCnt    <= '0;
            bus.busy     <= 1'b1;
            bus.ce       <= !bus.die_sel;
            bus.cmd_mode <= MODE_CMD;
            bus.dq_out   <= cmd1Byte(op_t'(bus.op));
            r_state      <= ST_CMD1;
          end
        end
        ST_CMD1: begin
          if (!r_gap) begin
            r_gap <= 1'b1;
          end else begin
            r_gap <= 1'b0;
            if (r_op == OP_RESET) begin
              r_waitCnt <= '0;
              r_state   <= ST_WAIT_WB;
            end else begin
              r_addrIdx    <= (r_op == OP_ERASE) ? 3'd2 : 3'd0;
              bus.cmd_mode <= MODE_ADDR;
              bus.dq_out   <= (r_op == OP_ERASE) ? r_rowAddr[7:0] : r_colAddr[7:0];
              r_state      <= ST_ADDR;
            end
          end
        end
        ST_ADDR: begin
          if (!r_gap) begin
            r_gap <= 1'b1;
          end else if (!w_lastAddr) begin
            r_gap        <= 1'b0;
            r_addrIdx    <= r_addrIdx + 3'd1;
            bus.cmd_mode <= MODE_ADDR;
            bus.dq_out   <= addrByte(r_addrIdx + 3'd1, r_colAddr, r_rowAddr);
          end else begin
            r_gap <= 1'b0;
            if (r_op == OP_PROGRAM) begin
              r_state <= ST_DIN;
              if (bus.wdata_valid) begin
                bus.cmd_mode    <= MODE_DIN;
                bus.dq_out      <= bus.wdata;
                bus.wdata_ready <= 1'b1;
                if (w_lastByte) r_pageDone <= 1'b1;
                else            r_byteCnt  <= r_byteCnt + 1'b1;
              end
            end else begin
              bus.cmd_mode <= MODE_CMD;
              bus.dq_out   <= cmd2Byte(r_op);
              r_state      <= ST_CMD2;
            end
          end
        end
        ST_DIN: begin
          if (r_pageDone) begin
            bus.cmd_mode <= MODE_CMD;
            bus.dq_out   <= cmd2Byte(r_op);
            r_state      <= ST_CMD2;
          end else if (bus.wdata_valid) begin
            bus.cmd_mode    <= MODE_DIN;
            bus.dq_out      <= bus.wdata;
            bus.wdata_ready <= 1'b1;
            if (w_lastByte) r_pageDone <= 1'b1;
            else            r_byteCnt  <= r_byteCnt + 1'b1;
          end
        end
        ST_CMD2: begin
          if (!r_gap) begin
            r_gap <= 1'b1;
          end else begin
            r_gap     <= 1'b0;
            r_waitCnt <= '0;
            r_state   <= ST_WAIT_WB;
          end
        end
        ST_WAIT_WB: begin
          if (r_waitCnt == TWB_LAST) begin
            r_waitCnt <= '0;
            r_state   <= ST_WAIT_RB;
          end else begin
            r_waitCnt <= r_waitCnt + 1'b1;
          end
        end
        ST_WAIT_RB: begin
          if (w_rbReady) begin
            if (r_op == OP_READ) begin
              r_state <= ST_DOUT;
              if (bus.rdata_ready) begin
                bus.cmd_mode     <= MODE_DOUT;
                bus.rdata_strobe <= 1'b1;
                if (w_lastByte) r_pageDone <= 1'b1;
                else            r_byteCnt  <= r_byteCnt + 1'b1;
              end
            end else begin
              bus.done <= 1'b1;
              r_state  <= ST_DONE;
            end
          end else if (r_waitCnt == TO_LAST) begin
            r_waitCnt   <= r_waitCnt + 1'b1;
            bus.done    <= 1'b1;
            bus.timeout <= 1'b1;
            r_state     <= ST_DONE;
          end else begin
            r_waitCnt <= r_waitCnt + 1'b1;
          end
        end
        ST_DOUT: begin
          if (r_pageDone) begin
            bus.done <= 1'b1;
            r_state  <= ST_DONE;
          end else if (bus.rdata_ready) begin
            bus.cmd_mode     <= MODE_DOUT;
            bus.rdata_strobe <= 1'b1;
            if (w_lastByte) r_pageDone <= 1'b1;
            else            r_byteCnt  <= r_byteCnt + 1'b1;
          end
        end
        ST_DONE: begin
          bus.cmd_mode <= MODE_STANDBY;
          bus.ce       <= 1'b1;
          bus.busy     <= 1'b0;
          r_state      <= ST_IDLE;
        end
        default: begin
          bus.cmd_mode <= MODE_STANDBY;
          bus.busy     <= 1'b0;
          r_state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_flash_op_sequencer.sv
// tb_flash_op_sequencer
//   Directed self-checking bench for flash_op_sequencer, built with a 4-byte
//   page, 10-cycle tWB and a 100-cycle ready/busy timeout so every operation
//   finishes in a few hundred cycles. Expected bus sequences are written out
//   as {mode, byte} entries.
module tb_flash_op_sequencer;

  localparam int PAGE_BYTES = 4;
  localparam int TWB        = 10;
  localparam int TIMEOUT    = 100;

  localparam logic [1:0] OP_RESET   = 2'd0;
  localparam logic [1:0] OP_READ    = 2'd1;
  localparam logic [1:0] OP_PROGRAM = 2'd2;
  localparam logic [1:0] OP_ERASE   = 2'd3;

  logic clock_100 = 1'b0;
  logic rst = 1'b1;
  int totalChecks = 0;
  int badChecks = 0;
  logic expCe = 1'b1;
  logic [11:0] expQ[$];

  flash_op_sequencer_if bus();

  flash_op_sequencer #(
    .PAGE_BYTES(PAGE_BYTES),
    .TWB_CYCLES(TWB),
    .TIMEOUT_CYCLES(TIMEOUT),
    .CNT_W(12)
  ) dut (
    .clock_100(clock_100),
    .rst(rst),
    .bus(bus)
  );

  // 100 MHz clock.
  always #5 clock_100 = ~clock_100;

  // Hard stop in case the design never returns a done pulse.
  initial begin
    #300000;
    $display("[TB] FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clock_100);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    totalChecks++;
    if (got !== exp) begin
      badChecks++;
      $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] op, input logic die,
                               input logic [15:0] col, input logic [23:0] row);
    bus.op       = op;
    bus.die_sel  = die;
    bus.col_addr = col;
    bus.row_addr = row;
    bus.start    = 1'b1;
    expCe        = !die;
    step();
    bus.start    = 1'b0;
  endtask

  task automatic pushIdle(input int n);
    for (int i = 0; i < n; i++) expQ.push_back(12'h100);
  endtask

  // Walk expQ one cycle per entry, checking mode, ce and the byte for
  // command/address/data-input modes.
  task automatic checkSeq(input string tag);
    logic [11:0] e;
    logic [2:0]  m;
    for (int i = 0; i < expQ.size(); i++) begin
      e = expQ[i];
      m = e[10:8];
      checkOutput($sformatf("%s[%0d].mode", tag, i), 32'(bus.cmd_mode), 32'(m));
      checkOutput($sformatf("%s[%0d].ce", tag, i), 32'(bus.ce), 32'(expCe));
      if (m >= 3'd3 && m <= 3'd5)
        checkOutput($sformatf("%s[%0d].dq", tag, i), 32'(bus.dq_out), 32'(e[7:0]));
      step();
    end
  endtask

  task automatic waitDone(input string tag, input int maxCycles);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < maxCycles; n++) begin
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    checkOutput(tag, 32'(seen), 1);
  endtask

  initial begin
    int doneCount;
    int strobes;
    int badStrobe;
    int doneIter;
    logic readyTog;
    logic prevReady;

    bus.start       = 1'b0;
    bus.op          = 2'd0;
    bus.die_sel     = 1'b0;
    bus.col_addr    = '0;
    bus.row_addr    = '0;
    bus.rb1_ctrl    = 1'b1;
    bus.rb2_ctrl    = 1'b1;
    bus.wdata_valid = 1'b0;
    bus.wdata       = '0;
    bus.rdata_ready = 1'b0;

    // Reset values
    rst = 1'b1;
    repeat (3) step();
    checkOutput("reset.mode", 32'(bus.cmd_mode), 0);
    checkOutput("reset.ce", 32'(bus.ce), 1);
    checkOutput("reset.dq", 32'(bus.dq_out), 0);
    checkOutput("reset.wready", 32'(bus.wdata_ready), 0);
    checkOutput("reset.strobe", 32'(bus.rdata_strobe), 0);
    checkOutput("reset.busy", 32'(bus.busy), 0);
    checkOutput("reset.done", 32'(bus.done), 0);
    checkOutput("reset.timeout", 32'(bus.timeout), 0);
    rst = 1'b0;
    step();

    // Test 1: reset in the middle of a READ aborts with no done pulse
    $display("[TB] reset mid-read");
    applyStimulus(OP_READ, 1'b0, 16'h0040, 24'h000100);
    checkOutput("rst.started", 32'(bus.busy), 1);
    repeat (4) step();
    rst = 1'b1;
    doneCount = 0;
    step();
    checkOutput("rst.mode", 32'(bus.cmd_mode), 0);
    checkOutput("rst.busy", 32'(bus.busy), 0);
    checkOutput("rst.ce", 32'(bus.ce), 1);
    if (bus.done) doneCount++;
    step();
    if (bus.done) doneCount++;
    step();
    if (bus.done) doneCount++;
    checkOutput("rst.noDone", 32'(doneCount), 0);
    rst = 1'b0;
    step();
    applyStimulus(OP_RESET, 1'b0, 16'h0000, 24'h000000);
    checkOutput("rst.next.mode", 32'(bus.cmd_mode), 3);
    checkOutput("rst.next.dq", 32'(bus.dq_out), 32'h FF);
    checkOutput("rst.next.busy", 32'(bus.busy), 1);
    waitDone("rst.next.done", 40);
    step();
    checkOutput("rst.next.idle", 32'(bus.cmd_mode), 0);

    // Test 2: ERASE die 2, unselected rb1 left ready and must not finish it
    $display("[TB] erase die 2");
    bus.rb2_ctrl = 1'b0;
    bus.rb1_ctrl = 1'b1;
    applyStimulus(OP_ERASE, 1'b1, 16'hFFFF, 24'h012345);
    expQ = '{12'h360, 12'h100, 12'h445, 12'h100, 12'h423, 12'h100,
             12'h401, 12'h100, 12'h3D0, 12'h100};
    pushIdle(TWB);
    checkSeq("erase");
    doneCount = 0;
    for (int i = 0; i < 50; i++) begin
      if (bus.done || bus.cmd_mode != 3'd1 || bus.ce != 1'b0) doneCount++;
      step();
    end
    checkOutput("erase.rbwait", 32'(doneCount), 0);
    bus.rb2_ctrl = 1'b1;
    step();
    checkOutput("erase.done", 32'(bus.done), 1);
    checkOutput("erase.doneMode", 32'(bus.cmd_mode), 1);
    checkOutput("erase.noTimeout", 32'(bus.timeout), 0);
    checkOutput("erase.busyOnDone", 32'(bus.busy), 1);
    step();
    checkOutput("erase.idle", 32'(bus.cmd_mode), 0);
    checkOutput("erase.busyOff", 32'(bus.busy), 0);
    checkOutput("erase.donePulse", 32'(bus.done), 0);

    // Test 3: PROGRAM with a two-cycle valid drop before the third byte
    $display("[TB] program die 1");
    bus.wdata_valid = 1'b1;
    bus.wdata       = 8'hAA;
    applyStimulus(OP_PROGRAM, 1'b0, 16'h0010, 24'h000002);
    expQ = '{12'h380, 12'h100, 12'h410, 12'h100, 12'h400, 12'h100,
             12'h402, 12'h100, 12'h400, 12'h100, 12'h400, 12'h100};
    checkSeq("prog.hdr");
    checkOutput("prog.d0.mode", 32'(bus.cmd_mode), 5);
    checkOutput("prog.d0.dq", 32'(bus.dq_out), 32'hAA);
    checkOutput("prog.d0.ready", 32'(bus.wdata_ready), 1);
    bus.wdata = 8'hBB;
    step();
    checkOutput("prog.d1.mode", 32'(bus.cmd_mode), 5);
    checkOutput("prog.d1.dq", 32'(bus.dq_out), 32'hBB);
    bus.wdata_valid = 1'b0;
    bus.wdata       = 8'h55;
    step();
    checkOutput("prog.stall0.mode", 32'(bus.cmd_mode), 1);
    checkOutput("prog.stall0.ready", 32'(bus.wdata_ready), 0);
    step();
    checkOutput("prog.stall1.mode", 32'(bus.cmd_mode), 1);
    bus.wdata_valid = 1'b1;
    bus.wdata       = 8'hCC;
    step();
    checkOutput("prog.d2.mode", 32'(bus.cmd_mode), 5);
    checkOutput("prog.d2.dq", 32'(bus.dq_out), 32'hCC);
    bus.wdata = 8'hDD;
    step();
    checkOutput("prog.d3.mode", 32'(bus.cmd_mode), 5);
    checkOutput("prog.d3.dq", 32'(bus.dq_out), 32'hDD);
    bus.wdata = 8'hEE;
    step();
    bus.wdata_valid = 1'b0;
    expQ = '{12'h310, 12'h100};
    pushIdle(TWB + 1);
    checkSeq("prog.tail");
    checkOutput("prog.done", 32'(bus.done), 1);
    checkOutput("prog.noTimeout", 32'(bus.timeout), 0);
    step();
    checkOutput("prog.idle", 32'(bus.cmd_mode), 0);

    // Test 4: READ die 1 with rdata_ready toggling; rb2 low is ignored
    $display("[TB] read die 1");
    bus.rb1_ctrl = 1'b1;
    bus.rb2_ctrl = 1'b0;
    applyStimulus(OP_READ, 1'b0, 16'h1234, 24'hABCDEF);
    expQ = '{12'h300, 12'h100, 12'h434, 12'h100, 12'h412, 12'h100,
             12'h4EF, 12'h100, 12'h4CD, 12'h100, 12'h4AB, 12'h100,
             12'h330, 12'h100};
    pushIdle(TWB);
    checkSeq("read.hdr");
    strobes   = 0;
    badStrobe = 0;
    doneIter  = -1;
    readyTog  = 1'b1;
    for (int i = 0; i < 40; i++) begin
      bus.rdata_ready = readyTog;
      prevReady       = readyTog;
      readyTog        = !readyTog;
      step();
      if (bus.rdata_strobe) begin
        strobes++;
        if (!prevReady || bus.cmd_mode != 3'd6) badStrobe++;
      end
      if (bus.done) begin
        doneIter = i;
        break;
      end
    end
    bus.rdata_ready = 1'b0;
    checkOutput("read.strobes", 32'(strobes), PAGE_BYTES);
    checkOutput("read.strobeOnReady", 32'(badStrobe), 0);
    checkOutput("read.doneCycle", 32'(doneIter), 7);
    checkOutput("read.noTimeout", 32'(bus.timeout), 0);
    step();
    checkOutput("read.idle", 32'(bus.cmd_mode), 0);
    bus.rb2_ctrl = 1'b1;

    // Test 5: RESET with rb1 stuck busy times out after 100 cycles
    $display("[TB] reset op timeout");
    bus.rb1_ctrl = 1'b0;
    bus.rb2_ctrl = 1'b1;
    applyStimulus(OP_RESET, 1'b0, 16'h0000, 24'h000000);
    expQ = '{12'h3FF, 12'h100};
    pushIdle(TWB);
    checkSeq("tmo.hdr");
    doneCount = 0;
    for (int i = 0; i < TIMEOUT; i++) begin
      if (bus.done || bus.timeout) doneCount++;
      step();
    end
    checkOutput("tmo.early", 32'(doneCount), 0);
    checkOutput("tmo.done", 32'(bus.done), 1);
    checkOutput("tmo.timeout", 32'(bus.timeout), 1);
    checkOutput("tmo.mode", 32'(bus.cmd_mode), 1);
    step();
    checkOutput("tmo.idle", 32'(bus.cmd_mode), 0);
    checkOutput("tmo.pulse", 32'(bus.timeout), 0);
    checkOutput("tmo.busyOff", 32'(bus.busy), 0);
    bus.rb1_ctrl = 1'b1;

    // Test 6: start held through busy and done; taken only once back in IDLE
    $display("[TB] start while busy");
    applyStimulus(OP_RESET, 1'b1, 16'h0000, 24'h000000);
    bus.start   = 1'b1;
    bus.op      = OP_PROGRAM;
    bus.die_sel = 1'b0;
    expQ = '{12'h3FF, 12'h100};
    pushIdle(TWB + 1);
    checkSeq("busy.hdr");
    checkOutput("busy.done", 32'(bus.done), 1);
    checkOutput("busy.busyOnDone", 32'(bus.busy), 1);
    step();
    checkOutput("busy.idle", 32'(bus.cmd_mode), 0);
    checkOutput("busy.busyOff", 32'(bus.busy), 0);
    step();
    checkOutput("busy.accept.mode", 32'(bus.cmd_mode), 3);
    checkOutput("busy.accept.dq", 32'(bus.dq_out), 32'h80);
    checkOutput("busy.accept.ce", 32'(bus.ce), 1);
    checkOutput("busy.accept.busy", 32'(bus.busy), 1);
    bus.start = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    checkOutput("busy.abort", 32'(bus.cmd_mode), 0);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
